spi_cmd_ctrl: RTL and testbench
===============================

// Module: spi_cmd_ctrl
// PURPOSE
//  Command sequencer behind the SPI slave receiver. Consumes 16-bit words (rx_evt/rx_data),
//  parses a header word, and runs burst register read/write transactions on a simple
//  req/ack register bus. Read data goes to a tx word stream for the SPI response path.
//  Reports completion and errors (bus timeout, frame gap timeout, overrun).
// PARAMETERS
//  ACK_TIMEOUT   32'd256   user_clk cycles allowed from o_reg_req rise to i_reg_ack
//  FRAME_TIMEOUT 32'd4096  max user_clk cycles between write-burst words (1 word @2.5MHz = 640)
//  ADDR_INC      1'b1      1: address +1 per beat (wraps 8'hFF->8'h00); 0: fixed address
// PORTS
//  user_clk     in   1   clock
//  user_rst     in   1   synchronous reset, active high
//  i_rx_evt     in   1   one-cycle pulse: i_rx_data valid (from SPI slave)
//  i_rx_data    in   16  received word
//  o_reg_req    out  1   register bus request, held until i_reg_ack or timeout
//  o_reg_wr     out  1   1 = write, 0 = read; stable while o_reg_req
//  o_reg_addr   out  8   register address; stable while o_reg_req
//  o_reg_wdata  out  16  write data; stable while o_reg_req
//  i_reg_ack    in   1   one-cycle completion pulse
//  i_reg_rdata  in   16  read data, valid with i_reg_ack
//  o_tx_valid   out  1   read word available
//  o_tx_data    out  16  read word
//  i_tx_ready   in   1   tx path accepts word when o_tx_valid & i_tx_ready
//  o_busy       out  1   high whenever state != IDLE
//  o_done       out  1   one-cycle pulse: burst finished without error
//  o_err        out  1   one-cycle pulse: burst aborted
//  o_err_code   out  2   1 ack timeout, 2 frame timeout, 3 overrun; held until next o_err
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pending buffer empty; counters 0.
//  Header word: [15] WR, [14:12] reserved (ignored), [11:8] LEN (beats = LEN+1, 1..16), [7:0] ADDR.
//  States: IDLE, WAIT_DATA, BUS, TX_PUSH, ERR.
//   IDLE: i_rx_evt -> latch header. WR=1 -> WAIT_DATA; WR=0 -> BUS (read; o_reg_req high next cycle).
//   WAIT_DATA: word from pending buffer or i_rx_evt -> o_reg_wdata, BUS; o_reg_req high next cycle.
//     Gap counter > FRAME_TIMEOUT -> ERR(2).
//   BUS: o_reg_req held. i_reg_ack -> o_reg_req low next cycle; read: capture rdata -> TX_PUSH.
//     Write: last beat -> IDLE + o_done; else -> WAIT_DATA. Ack wait > ACK_TIMEOUT -> ERR(1), req dropped.
//   TX_PUSH: o_tx_valid held until i_tx_ready; then last beat -> IDLE + o_done, else BUS.
//   ERR: one cycle; o_err pulse, o_err_code set; -> IDLE. Remaining beats discarded.
//  Beat counter 4 bits, compared against LEN. Address: after each ack, +1 when ADDR_INC=1, else unchanged.
//  o_reg_req is low for >=1 cycle between beats.
//  Write buffering: 1-entry pending buffer catches i_rx_evt during BUS. A word arriving while the
//   buffer is full -> ERR(3). A word arriving in the same cycle as i_reg_ack is captured, not lost.
//  Read bursts: i_rx_evt (master dummy words) ignored.
//  i_reg_ack and timeout expiry in the same cycle: ack wins. Spurious i_reg_ack outside BUS: ignored.
//  Gap counter restarts on every accepted word.
//  Reset mid-burst: immediate return to IDLE, o_reg_req/o_tx_valid drop, no o_done/o_err.
// STRUCTURE
//  Shared package spi_ctrl_pkg: state encodings, error codes, header bit positions (WR/LEN/ADDR).
//  Sub-module spi_ctrl_timer: loadable up-counter with clear and expiry flag, instantiated
//   twice (ack timeout, frame gap timeout).
// TESTING
//  1. Header 16'h8205 + words 1111,2222,3333 -> writes addr 05/06/07 with those data; one o_done.
//  2. Header 16'h0110, slave acks rdata A5A5 then 5A5A -> tx words A5A5,5A5A; reads at 10,11; o_done.
//  3. ADDR_INC=1, header 16'h81FF + 2 words -> addresses FF then 00.
//  4. Read, no i_reg_ack for 257 cycles -> o_reg_req low, o_err, o_err_code=1, back to IDLE.
//  5. Write LEN=3, stop after 2 words, wait 4097 cycles -> o_err, code 2; next header accepted.
//  6. Ack held off while 2 extra words arrive -> 1st buffered, 2nd gives o_err code 3. Ack+rx_evt same cycle -> no loss.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer: FSM states, error codes
// and header word field positions.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_BUS       = 3'd2,
    ST_TX_PUSH   = 3'd3,
    ST_ERR       = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ACK_TO   = 2'd1,
    ERR_FRAME_TO = 2'd2,
    ERR_OVERRUN  = 2'd3
  } err_e;

  localparam int unsigned HDR_WR_BIT   = 15;
  localparam int unsigned HDR_LEN_MSB  = 11;
  localparam int unsigned HDR_LEN_LSB  = 8;
  localparam int unsigned HDR_ADDR_MSB = 7;
  localparam int unsigned HDR_ADDR_LSB = 0;

endpackage

// File: rtl/spi_ctrl_timer.sv
// Saturating up-counter with synchronous clear; flags expiry once the count
// reaches LIMIT, i.e. after LIMIT+1 enabled cycles since the last clear.
module spi_ctrl_timer #(
  parameter logic [31:0] LIMIT = 32'd256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign expired_o = (cnt_q >= LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind the SPI slave: parses a header word and runs burst
// register reads/writes on a req/ack bus, streaming read data to the tx path.
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter logic [31:0] ACK_TIMEOUT   = 32'd256,
  parameter logic [31:0] FRAME_TIMEOUT = 32'd4096,
  parameter logic        ADDR_INC      = 1'b1
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        i_rx_evt,
  input  logic [15:0] i_rx_data,
  output logic        o_reg_req,
  output logic        o_reg_wr,
  output logic [7:0]  o_reg_addr,
  output logic [15:0] o_reg_wdata,
  input  logic        i_reg_ack,
  input  logic [15:0] i_reg_rdata,
  output logic        o_tx_valid,
  output logic [15:0] o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_q, beat_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] txd_q, txd_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic [1:0]  code_q, code_d;
  logic        done_q, done_d;
  logic        req_q, tx_valid_q, busy_q, err_q;
  logic        ack_exp, gap_exp;

  spi_ctrl_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_tmr (
    .clk_i    (user_clk),
    .rst_i    (user_rst),
    .clr_i    (state_q != ST_BUS),
    .en_i     (state_q == ST_BUS),
    .expired_o(ack_exp)
  );

  spi_ctrl_timer #(.LIMIT(FRAME_TIMEOUT)) u_gap_tmr (
    .clk_i    (user_clk),
    .rst_i    (user_rst),
    .clr_i    (state_q != ST_WAIT_DATA),
    .en_i     (state_q == ST_WAIT_DATA),
    .expired_o(gap_exp)
  );

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    txd_d       = txd_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    code_d      = code_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_evt) begin
          wr_d    = i_rx_data[HDR_WR_BIT];
          len_d   = i_rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
          addr_d  = i_rx_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
          beat_d  = '0;
          state_d = i_rx_data[HDR_WR_BIT] ? ST_WAIT_DATA : ST_BUS;
        end
      end
      ST_WAIT_DATA: begin
        // A buffered word goes first; a word arriving now refills the buffer.
        if (pend_vld_q) begin
          wdata_d    = pend_data_q;
          pend_vld_d = i_rx_evt;
          if (i_rx_evt) pend_data_d = i_rx_data;
          state_d    = ST_BUS;
        end else if (i_rx_evt) begin
          wdata_d = i_rx_data;
          state_d = ST_BUS;
        end else if (gap_exp) begin
          code_d  = ERR_FRAME_TO;
          state_d = ST_ERR;
        end
      end
      ST_BUS: begin
        if (i_reg_ack) begin
          if (ADDR_INC) addr_d = addr_q + 8'd1;
          if (wr_q) begin
            beat_d = beat_q + 4'd1;
            if (beat_q == len_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT_DATA;
            end
          end else begin
            txd_d   = i_reg_rdata;
            state_d = ST_TX_PUSH;
          end
        end else if (ack_exp) begin
          code_d  = ERR_ACK_TO;
          state_d = ST_ERR;
        end
        if (wr_q && i_rx_evt) begin
          if (pend_vld_q) begin
            code_d  = ERR_OVERRUN;
            state_d = ST_ERR;
            done_d  = 1'b0;
          end else begin
            pend_vld_d  = 1'b1;
            pend_data_d = i_rx_data;
          end
        end
      end
      ST_TX_PUSH: begin
        if (i_tx_ready) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_BUS;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Words left over at the end of a burst are never carried into the next one.
    if (state_d == ST_IDLE) pend_vld_d = 1'b0;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      txd_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      code_q      <= ERR_NONE;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      txd_q       <= txd_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      code_q      <= code_d;
      done_q      <= done_d;
      req_q       <= (state_d == ST_BUS);
      tx_valid_q  <= (state_d == ST_TX_PUSH);
      busy_q      <= (state_d != ST_IDLE);
      err_q       <= (state_d == ST_ERR);
    end
  end

  assign o_reg_req   = req_q;
  assign o_reg_wr    = wr_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = wdata_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_tx_data   = txd_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_err_code  = code_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed scenarios plus random bursts
// compared against a transaction-level expectation built from the header.
module tb_spi_cmd_ctrl;

  logic        clk, rst;
  logic        rx_evt, reg_ack, tx_ready;
  logic [15:0] rx_data, reg_rdata;
  logic        req, wr, tx_valid, busy, done, err;
  logic [7:0]  addr;
  logic [15:0] wdata, tx_data;
  logic [1:0]  err_code;

  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [1:0]  code_seen = 2'd0;
  bit          auto_ack = 1'b1;
  int          ack_dly = 0;
  logic [24:0] bus_log[$];
  logic [15:0] exp_tx[$];
  logic [15:0] obs_tx[$];
  logic [15:0] rdq[$];

  spi_cmd_ctrl dut (
    .user_clk   (clk),
    .user_rst   (rst),
    .i_rx_evt   (rx_evt),
    .i_rx_data  (rx_data),
    .o_reg_req  (req),
    .o_reg_wr   (wr),
    .o_reg_addr (addr),
    .o_reg_wdata(wdata),
    .i_reg_ack  (reg_ack),
    .i_reg_rdata(reg_rdata),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // One clock: record handshakes seen at the edge, then play bus slave and tx sink.
  task automatic tick();
    logic        hs_bus, hs_tx, b_wr;
    logic [7:0]  b_addr;
    logic [15:0] b_data, b_rd, t_data;
    hs_bus = req && reg_ack;
    b_wr   = wr;
    b_addr = addr;
    b_data = wdata;
    b_rd   = reg_rdata;
    hs_tx  = tx_valid && tx_ready;
    t_data = tx_data;
    @(posedge clk);
    #1;
    if (hs_bus) begin
      bus_log.push_back({b_wr, b_addr, b_data});
      if (!b_wr) exp_tx.push_back(b_rd);
    end
    if (hs_tx) obs_tx.push_back(t_data);
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      code_seen = err_code;
    end
    rx_evt  = 1'b0;
    reg_ack = 1'b0;
    if (auto_ack && req) begin
      if (ack_dly == 0) begin
        reg_ack   = 1'b1;
        reg_rdata = (rdq.size() > 0) ? rdq.pop_front() : 16'($urandom);
        ack_dly   = $urandom_range(0, 3);
      end else begin
        ack_dly--;
      end
    end
    tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] w);
    rx_evt  = 1'b1;
    rx_data = w;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int i = 0;
    while (!req && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(req), 32'd1);
  endtask

  task automatic clear_logs();
    bus_log.delete();
    exp_tx.delete();
    obs_tx.delete();
  endtask

  task automatic check_bus(input string tag, input int idx, input logic e_wr,
                           input logic [7:0] e_addr, input logic [15:0] e_data, input bit chk_data);
    if (idx >= bus_log.size()) begin
      check({tag, "_count"}, 32'(bus_log.size()), 32'(idx + 1));
    end else begin
      check({tag, "_wr"}, 32'(bus_log[idx][24]), 32'(e_wr));
      check({tag, "_addr"}, 32'(bus_log[idx][23:16]), 32'(e_addr));
      if (chk_data) check({tag, "_data"}, 32'(bus_log[idx][15:0]), 32'(e_data));
    end
  endtask

  task automatic check_tx(input string tag, input int idx, input logic [15:0] e);
    if (idx >= obs_tx.size()) check({tag, "_count"}, 32'(obs_tx.size()), 32'(idx + 1));
    else check(tag, 32'(obs_tx[idx]), 32'(e));
  endtask

  initial begin
    int d0, e0, i;
    rst = 1'b1; rx_evt = 1'b0; rx_data = '0; reg_ack = 1'b0; reg_rdata = '0; tx_ready = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_req", 32'(req), 0);
    check("rst_wr", 32'(wr), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_txv", 32'(tx_valid), 0);
    check("rst_txd", 32'(tx_data), 0);
    check("rst_flags", 32'({busy, done, err, err_code}), 0);

    // Three-beat write burst
    clear_logs(); d0 = done_cnt;
    send(16'h8205); idle(4); send(16'h1111); idle(8); send(16'h2222); idle(8); send(16'h3333);
    wait_idle("t1_idle", 100);
    check("t1_beats", 32'(bus_log.size()), 3);
    check_bus("t1_b0", 0, 1'b1, 8'h05, 16'h1111, 1'b1);
    check_bus("t1_b1", 1, 1'b1, 8'h06, 16'h2222, 1'b1);
    check_bus("t1_b2", 2, 1'b1, 8'h07, 16'h3333, 1'b1);
    check("t1_done", 32'(done_cnt - d0), 1);

    // Two-beat read burst with fixed slave data
    clear_logs(); d0 = done_cnt;
    rdq.push_back(16'hA5A5); rdq.push_back(16'h5A5A);
    send(16'h0110);
    wait_idle("t2_idle", 100);
    check_bus("t2_b0", 0, 1'b0, 8'h10, 16'h0, 1'b0);
    check_bus("t2_b1", 1, 1'b0, 8'h11, 16'h0, 1'b0);
    check_tx("t2_tx0", 0, 16'hA5A5);
    check_tx("t2_tx1", 1, 16'h5A5A);
    check("t2_done", 32'(done_cnt - d0), 1);

    // Address wrap
    clear_logs();
    send(16'h81FF); idle(3); send(16'hCAFE); idle(8); send(16'hF00D);
    wait_idle("t3_idle", 100);
    check_bus("t3_b0", 0, 1'b1, 8'hFF, 16'hCAFE, 1'b1);
    check_bus("t3_b1", 1, 1'b1, 8'h00, 16'hF00D, 1'b1);

    // Overrun: ack held off while two extra words arrive
    clear_logs(); e0 = err_cnt; d0 = done_cnt; auto_ack = 1'b0;
    send(16'h8210); idle(2); send(16'h000A);
    wait_req("t6_req", 10);
    send(16'h000B); idle(2); send(16'h000C);
    idle(2);
    check("t6_err", 32'(err_cnt - e0), 1);
    check("t6_code", 32'(code_seen), 3);
    check("t6_req_low", 32'(req), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_nodone", 32'(done_cnt - d0), 0);
    check("t6_nobus", 32'(bus_log.size()), 0);

    // Word arriving in the same cycle as the ack
    clear_logs(); d0 = done_cnt;
    send(16'h8120); idle(2); send(16'h1234);
    wait_req("t6b_req", 10);
    reg_ack = 1'b1; reg_rdata = 16'h0;
    send(16'h5678);
    auto_ack = 1'b1;
    wait_idle("t6b_idle", 100);
    check_bus("t6b_b0", 0, 1'b1, 8'h20, 16'h1234, 1'b1);
    check_bus("t6b_b1", 1, 1'b1, 8'h21, 16'h5678, 1'b1);
    check("t6b_done", 32'(done_cnt - d0), 1);

    // Read burst with master dummy words ignored
    clear_logs(); d0 = done_cnt; auto_ack = 1'b0;
    send(16'h0230);
    wait_req("rd_req", 10);
    send(16'h8FFF); idle(2); send(16'h0000); idle(2); send(16'h1234);
    auto_ack = 1'b1;
    wait_idle("rd_idle", 200);
    check("rd_beats", 32'(bus_log.size()), 3);
    for (int k = 0; k < 3; k++) check_bus("rd_b", k, 1'b0, 8'h30 + 8'(k), 16'h0, 1'b0);
    for (int k = 0; k < exp_tx.size(); k++) check_tx("rd_tx", k, exp_tx[k]);
    check("rd_done", 32'(done_cnt - d0), 1);

    // Reset in the middle of a burst
    clear_logs(); d0 = done_cnt; e0 = err_cnt; auto_ack = 1'b0;
    send(16'h8340); idle(2); send(16'h4444);
    wait_req("mr_req", 10);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mr_req_low", 32'(req), 0);
    check("mr_busy", 32'(busy), 0);
    idle(3);
    check("mr_no_flags", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
    auto_ack = 1'b1;

    // Ack timeout
    e0 = err_cnt; auto_ack = 1'b0;
    send(16'h0077);
    idle(250);
    check("ato_req_held", 32'(req), 1);
    i = 0;
    while (err_cnt == e0 && i < 60) begin tick(); i++; end
    check("ato_err", 32'(err_cnt - e0), 1);
    check("ato_code", 32'(code_seen), 1);
    check("ato_req_low", 32'(req), 0);
    idle(3);
    check("ato_busy", 32'(busy), 0);
    check("ato_code_hold", 32'(err_code), 1);
    auto_ack = 1'b1;

    // Frame gap timeout, then a fresh header
    clear_logs(); e0 = err_cnt;
    send(16'h8300); idle(3); send(16'h0101); idle(8); send(16'h0202);
    idle(3900);
    check("fto_no_early", 32'(err_cnt - e0), 0);
    i = 0;
    while (err_cnt == e0 && i < 400) begin tick(); i++; end
    check("fto_err", 32'(err_cnt - e0), 1);
    check("fto_code", 32'(code_seen), 2);
    check("fto_beats", 32'(bus_log.size()), 2);
    wait_idle("fto_idle", 10);
    clear_logs(); d0 = done_cnt;
    send(16'h8042); idle(3); send(16'hBEEF);
    wait_idle("fto_next_idle", 100);
    check_bus("fto_next", 0, 1'b1, 8'h42, 16'hBEEF, 1'b1);
    check("fto_next_done", 32'(done_cnt - d0), 1);

    // Random bursts against the header-derived expectation
    for (int b = 0; b < 16; b++) begin
      logic        w;
      logic [3:0]  ln;
      logic [7:0]  a;
      logic [15:0] wd[16];
      w  = 1'($urandom_range(0, 1));
      ln = 4'($urandom_range(0, 7));
      a  = 8'($urandom);
      for (int k = 0; k < 16; k++) wd[k] = 16'($urandom);
      clear_logs(); d0 = done_cnt; e0 = err_cnt;
      send({w, 3'($urandom), ln, a});
      if (w) begin
        for (int k = 0; k <= int'(ln); k++) begin
          idle($urandom_range(6, 12));
          send(wd[k]);
        end
      end
      wait_idle("rnd_idle", 300);
      check("rnd_beats", 32'(bus_log.size()), 32'(ln) + 32'd1);
      for (int k = 0; k <= int'(ln); k++) check_bus("rnd_b", k, w, a + 8'(k), wd[k], w);
      if (!w) begin
        check("rnd_tx_cnt", 32'(obs_tx.size()), 32'(ln) + 32'd1);
        for (int k = 0; k < exp_tx.size(); k++) check_tx("rnd_tx", k, exp_tx[k]);
      end
      check("rnd_done", 32'(done_cnt - d0), 1);
      check("rnd_noerr", 32'(err_cnt - e0), 0);
      idle($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
